// File: rtl/inst_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : inst_axi_bridge
// Description : Single-outstanding SRAM-like instruction port to AXI4 read
//               bridge. Define INST_BRIDGE_RBUF_EN to register read data
//               through a DATA state (+1 cycle, no rdata->IF comb path).
// Revision    : 1.0 - initial release
// ============================================================================
module inst_axi_bridge #(
    parameter logic [3:0] ARID_VAL = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_DATA = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:2] addr_q;

    // Write-side and response-tag inputs carry no meaning for a read-only bridge.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
                             inst_sram_addr[1:0], inst_sram_wdata, rid, rresp, rlast};

    assign arid    = ARID_VAL;
    assign araddr  = {addr_q, 2'b00};
    assign arlen   = 8'd0;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    // Outputs are gated by reset so the reset cycle itself is quiet in every state.
    assign inst_sram_addr_ok = (state_q == S_IDLE) & inst_sram_req & ~reset;
    assign arvalid           = (state_q == S_AR) & ~reset;
    assign rready            = (state_q == S_R) & ~reset;

`ifdef INST_BRIDGE_RBUF_EN
    logic [31:0] rdata_q;
    assign inst_sram_data_ok = (state_q == S_DATA) & ~reset;
    assign inst_sram_rdata   = rdata_q;
`else
    assign inst_sram_data_ok = (state_q == S_R) & rvalid & ~reset;
    assign inst_sram_rdata   = rdata;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
`ifdef INST_BRIDGE_RBUF_EN
            rdata_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (inst_sram_req) begin
                        addr_q  <= inst_sram_addr[31:2];
                        state_q <= S_AR;
                    end
                end
                S_AR: begin
                    if (arready) begin
                        state_q <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid) begin
`ifdef INST_BRIDGE_RBUF_EN
                        rdata_q <= rdata;
                        state_q <= S_DATA;
`else
                        state_q <= S_IDLE;
`endif
                    end
                end
                // DATA lasts one cycle; in the unbuffered build it is unreachable.
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_inst_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_axi_bridge
// Description : Scoreboard bench for inst_axi_bridge with a behavioural AXI
//               read slave whose AR/R latencies are set per scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_axi_bridge;
`ifdef INST_BRIDGE_RBUF_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam logic [3:0] TB_ARID = 4'd5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_sram_req = 1'b0;
    logic        inst_sram_wr = 1'b0;
    logic [1:0]  inst_sram_size = 2'd2;
    logic [3:0]  inst_sram_wstrb = 4'd0;
    logic [31:0] inst_sram_addr = 32'd0;
    logic [31:0] inst_sram_wdata = 32'd0;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic        arvalid, rready;
    logic        arready = 1'b0;
    logic [3:0]  rid = TB_ARID;
    logic [31:0] rdata = 32'd0;
    logic [1:0]  rresp = 2'd0;
    logic        rlast = 1'b1;
    logic        rvalid = 1'b0;

    inst_axi_bridge #(.ARID_VAL(TB_ARID)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    int ar_lat = 0, r_lat = 0, ar_cnt = 0, r_cnt = 0;
    bit r_pending = 1'b0, r_done = 1'b0;
    logic [31:0] r_word = 32'd0, last_araddr = 32'd0, m_exp;
    int n_acc = 0, n_done = 0, acc_cyc = 0, done_cyc = -10, last_lat = 0;
    int outstanding = 0, b2b = 0;
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h1c000000) return 32'h02800c0c;
        return (a * 32'h9E3779B1) ^ 32'h5a5a0f0f;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural AXI slave, updated mid-cycle after the stimulus has settled.
    always @(posedge clk) begin
        #2;
        if (reset) begin
            arready = 1'b0; rvalid = 1'b0; rdata = 32'd0;
            r_pending = 1'b0; r_done = 1'b0; ar_cnt = 0;
        end else begin
            if (arvalid) begin
                arready = (ar_cnt >= ar_lat);
                ar_cnt++;
            end else begin
                arready = (ar_lat == 0);
                ar_cnt = 0;
            end
            if (r_done) begin
                rvalid = 1'b0;
                r_done = 1'b0;
            end
            if (r_pending) begin
                if (r_cnt >= r_lat) begin
                    rvalid = 1'b1; rdata = r_word; r_pending = 1'b0;
                end else begin
                    r_cnt++;
                end
            end
        end
    end

    // Scoreboard: expected address at addr_ok, expected word at AR handshake.
    always @(negedge clk) begin
        if (reset) begin
            q_addr.delete(); q_data.delete(); outstanding = 0;
        end else begin
            if (inst_sram_data_ok) begin
                total++;
                if (q_data.size() == 0) begin
                    bad++;
                    $display("FAIL data_unexpected: data_ok=1 rdata=%h with nothing pending (cycle %0d)", inst_sram_rdata, cyc);
                end else begin
                    m_exp = q_data.pop_front();
                    if (inst_sram_rdata !== m_exp) begin
                        bad++;
                        $display("FAIL rdata: got %h expected %h (cycle %0d)", inst_sram_rdata, m_exp, cyc);
                    end
                end
                last_lat = cyc - acc_cyc;
                done_cyc = cyc;
                n_done++;
                if (outstanding > 0) outstanding--;
            end
            if (inst_sram_addr_ok) begin
                total++;
                if (outstanding !== 0) begin
                    bad++;
                    $display("FAIL outstanding: addr_ok with %0d reads in flight, expected 0", outstanding);
                end
                outstanding++;
                n_acc++;
                acc_cyc = cyc;
                if (done_cyc == cyc - 1) b2b++;
                q_addr.push_back({inst_sram_addr[31:2], 2'b00});
            end
            if (arvalid) begin
                total++;
                if (q_addr.size() == 0) begin
                    bad++;
                    $display("FAIL araddr: arvalid=1 araddr=%h with no accepted request", araddr);
                end else if (araddr !== q_addr[0]) begin
                    bad++;
                    $display("FAIL araddr: got %h expected %h (cycle %0d)", araddr, q_addr[0], cyc);
                end
                if (arready) begin
                    total++;
                    if ({arid, arlen, arsize, arburst, arlock, arcache, arprot} !==
                        {TB_ARID, 8'd0, 3'd2, 2'd1, 2'd0, 4'd0, 3'd0}) begin
                        bad++;
                        $display("FAIL ar_fields: got id=%h len=%h size=%h burst=%h lock=%h cache=%h prot=%h expected id=%h len=0 size=2 burst=1 rest=0",
                                 arid, arlen, arsize, arburst, arlock, arcache, arprot, TB_ARID);
                    end
                    last_araddr = araddr;
                    if (q_addr.size() > 0) q_data.push_back(mem_word(q_addr.pop_front()));
                    r_word = mem_word(araddr);
                    r_pending = 1'b1;
                    r_cnt = 0;
                end
            end
            if (rvalid && rready) r_done = 1'b1;
        end
    end

    task automatic do_fetch(input logic [31:0] a, input int arl, input int rl, output bit ok);
        int n0;
        ok = 1'b0;
        @(posedge clk); #1;
        ar_lat = arl; r_lat = rl;
        inst_sram_req = 1'b1; inst_sram_addr = a;
        n0 = n_done;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (inst_sram_addr_ok) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        inst_sram_req = 1'b0;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk); #1;
                if (n_done > n0) begin ok = 1'b1; break; end
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        int n0;
        inst_sram_req = 1'b1;
        inst_sram_addr = 32'h00000010;
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({inst_sram_addr_ok, arvalid, rready, inst_sram_data_ok} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_quiet: addr_ok/arvalid/rready/data_ok=%b expected 0000",
                         {inst_sram_addr_ok, arvalid, rready, inst_sram_data_ok});
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        n0 = n_done;
        @(negedge clk);
        total++;
        if (inst_sram_addr_ok !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: addr_ok=%b expected 1", inst_sram_addr_ok);
        end
        @(posedge clk); #1;
        inst_sram_req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (n_done > n0) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL reset_first_fetch: done=0 expected 1 within 40 cycles"); end
    endtask

    task automatic test_basic();
        bit ok;
        do_fetch(32'h1c000000, 0, 0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_done: done=0 expected 1"); end
        total++;
        if (last_lat !== LAT) begin bad++; $display("FAIL basic_latency: got %0d expected %0d", last_lat, LAT); end
        total++;
        if (last_araddr !== 32'h1c000000) begin
            bad++; $display("FAIL basic_araddr: got %h expected 1c000000", last_araddr);
        end
    endtask

    task automatic test_ar_stall();
        bit ok;
        int n0;
        @(posedge clk); #1;
        ar_lat = 5; r_lat = 0;
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000000;
        n0 = n_done;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (inst_sram_addr_ok) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL stall_accept: addr_ok=0 expected 1 within 20 cycles"); end
        @(posedge clk); #1;
        inst_sram_req = 1'b0; inst_sram_addr = 32'h1c000040;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (arvalid !== 1'b1 || araddr !== 32'h1c000000) begin
                bad++;
                $display("FAIL stall_hold: arvalid=%b araddr=%h expected 1 1c000000 (stall %0d)", arvalid, araddr, i);
            end
        end
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (n_done > n0) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL stall_done: done=0 expected 1"); end
        total++;
        if (last_lat !== LAT + 5) begin bad++; $display("FAIL stall_latency: got %0d expected %0d", last_lat, LAT + 5); end
    endtask

    task automatic test_misaligned();
        bit ok;
        do_fetch(32'h1c000006, 0, 2, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL misaligned_done: done=0 expected 1"); end
        total++;
        if (last_araddr !== 32'h1c000004) begin
            bad++; $display("FAIL misaligned_araddr: got %h expected 1c000004", last_araddr);
        end
        total++;
        if (last_lat !== LAT + 2) begin bad++; $display("FAIL misaligned_latency: got %0d expected %0d", last_lat, LAT + 2); end
    endtask

    task automatic test_back_to_back();
        int acc0, done0, b0;
        bit seen;
        acc0 = n_acc; done0 = n_done; b0 = b2b;
        @(posedge clk); #1;
        ar_lat = 0; r_lat = 1;
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000100;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            seen = inst_sram_addr_ok;
            @(posedge clk); #1;
            if (seen) inst_sram_addr = inst_sram_addr + 32'd4;
        end
        inst_sram_req = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        total++;
        if ((n_acc - acc0) !== (n_done - done0) || (n_done - done0) < 3) begin
            bad++;
            $display("FAIL b2b_count: accepts=%0d data=%0d expected equal and >=3", n_acc - acc0, n_done - done0);
        end
        total++;
        if (b2b - b0 < 1) begin
            bad++; $display("FAIL b2b_gap: addr_ok right after data_ok seen %0d times, expected >=1", b2b - b0);
        end
    endtask

    task automatic test_reset_in_r();
        bit ok;
        int n0;
        @(posedge clk); #1;
        ar_lat = 0; r_lat = 8;
        inst_sram_req = 1'b1; inst_sram_addr = 32'h1c000200;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (inst_sram_addr_ok) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        inst_sram_req = 1'b0;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (rready) begin ok = 1'b1; break; end
            end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL rst_r_reach: rready=0 expected 1 within 10 cycles"); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({rready, inst_sram_data_ok} !== 2'b00) begin
            bad++; $display("FAIL rst_r_quiet: rready/data_ok=%b expected 00", {rready, inst_sram_data_ok});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        n0 = n_done;
        @(negedge clk);
        total++;
        if ({arvalid, rready, inst_sram_addr_ok, inst_sram_data_ok} !== 4'b0000) begin
            bad++;
            $display("FAIL rst_r_idle: arvalid/rready/addr_ok/data_ok=%b expected 0000",
                     {arvalid, rready, inst_sram_addr_ok, inst_sram_data_ok});
        end
        repeat (15) @(negedge clk);
        #1;
        total++;
        if (n_done !== n0) begin bad++; $display("FAIL rst_r_nodata: data_ok count %0d expected 0", n_done - n0); end
        do_fetch(32'h1c000300, 0, 0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rst_r_recover: done=0 expected 1"); end
        total++;
        if (last_lat !== LAT) begin bad++; $display("FAIL rst_r_latency: got %0d expected %0d", last_lat, LAT); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_ar_stall();
        test_misaligned();
        test_back_to_back();
        test_reset_in_r();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/inst_axi_bridge.md
# inst_axi_bridge

Read-only bridge between the IF stage's SRAM-like instruction port (`inst_sram_*`) and a 32-bit AXI4 read master interface. It accepts one fetch request at a time, issues a single-beat AXI read, and returns the word with a `data_ok` pulse. It sits directly upstream of IF_stage and is the only path by which fetched instructions enter the pipeline.

## Interface
Parameters:
- `ARID_VAL`, default 4'd0: constant driven on `arid`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high
- `inst_sram_req`  in  1  fetch request from IF
- `inst_sram_wr`  in  1  ignored; the bridge only performs reads
- `inst_sram_size`  in  2  ignored; always treated as a word
- `inst_sram_wstrb`  in  4  ignored
- `inst_sram_addr`  in  32  fetch address
- `inst_sram_wdata`  in  32  ignored
- `inst_sram_addr_ok`  out  1  request accepted this cycle
- `inst_sram_data_ok`  out  1  `inst_sram_rdata` valid this cycle; one-cycle pulse
- `inst_sram_rdata`  out  32  fetched word
- `arid`  out  4  = `ARID_VAL`
- `araddr`  out  32  `{latched_addr[31:2], 2'b00}`
- `arlen`  out  8  = 0
- `arsize`  out  3  = 3'b010
- `arburst`  out  2  = 2'b01
- `arlock`  out  2  = 0
- `arcache`  out  4  = 0
- `arprot`  out  3  = 0
- `arvalid`  out  1  AR handshake
- `arready`  in  1  AR handshake
- `rid`  in  4  ignored; at most one read is outstanding
- `rdata`  in  32  read data
- `rresp`  in  2  ignored
- `rlast`  in  1  ignored; every transfer is single-beat
- `rvalid`  in  1  R handshake
- `rready`  out  1  R handshake

## Operation
- States: IDLE, AR, R, and DATA (DATA exists only with the macro).
- **IDLE**
  - `addr_ok = inst_sram_req & ~reset`, driven combinationally.
  - On an accepted request, latch `inst_sram_addr` into `addr_r` and go to AR.
  - `addr_ok` is never asserted outside IDLE, so requests are serialised.
- **AR**
  - `arvalid = 1` with `araddr` driven from `addr_r`.
  - `araddr` stays stable until `arready` is seen.
  - On `arvalid & arready`, go to R.
- **R**
  - `rready = 1`.
  - On `rvalid`:
    - Without the macro: `data_ok = 1` and `inst_sram_rdata = rdata` in the same cycle (combinational), then go to IDLE.
    - With the macro: capture `rdata` into `rdata_r` and go to DATA.
- **DATA**: `data_ok = 1`, `inst_sram_rdata = rdata_r`, then go to IDLE.
- No backpressure on `data_ok`. IF always consumes it, including when it is cancelling a fetch; the bridge never discards or reorders data.
- Misaligned addresses are still read, with the low two bits forced to zero; IF masks the resulting instruction.
- A change on `inst_sram_addr` after `addr_ok` has no effect on the transfer in flight.

## Timing
- Reset values: `arvalid = 0`, `rready = 0`, `addr_ok = 0`, `data_ok = 0`, state = IDLE, `addr_r = 0`, `rdata_r = 0`.
- A reset in any state aborts the transfer and forces IDLE on the next edge. The AXI slave shares this reset.
- With request accepted in cycle t:
  - `arvalid` rises at t+1.
  - With `arready` seen at cycle a (a ≥ t+1) and `rvalid` at cycle r (r ≥ a+1), `data_ok` is asserted at r without the macro, or at r+1 with it.
- Minimum fetch latency is 2 cycles from `addr_ok` to `data_ok` without the macro, 3 cycles with it.
- The next `addr_ok` can occur in the cycle after `data_ok`.
- `arready` held high: AR completes in cycle t+1 and does not stall.
- `rvalid` held high while not in R: ignored, because `rready = 0`.

## Configuration
- `INST_BRIDGE_RBUF_EN`
  - Defined: R data is registered through the DATA state. `data_ok` and `inst_sram_rdata` come from flops, which breaks the `rdata` → IF combinational path at the cost of +1 cycle of latency.
  - Undefined: the DATA state and `rdata_r` do not exist, and `data_ok`/`rdata` pass through in the `rvalid` cycle.

## Test plan
- Reset high for 3 cycles with `req = 1`: `addr_ok`, `arvalid`, `rready` and `data_ok` all stay 0. In the first cycle after reset, `addr_ok = 1`.
- `req` with `addr = 0x1c000000`, `arready = 1` and `rvalid` one cycle after AR, returning `rdata = 0x02800c0c`:
  - `araddr = 0x1c000000`, `arlen = 0`, `arsize = 2`.
  - `data_ok` asserted with `rdata = 0x02800c0c` 2 cycles after `addr_ok` (3 cycles with the macro).
- `arready` held low for 5 cycles while `inst_sram_addr` changes to `0x1c000040`: `araddr` stays `0x1c000000` throughout, and `arvalid` stays high until the handshake.
- `addr = 0x1c000006`: `araddr = 0x1c000004`, and the read completes normally.
- `req` held high through a complete fetch: exactly one `addr_ok` per `data_ok`, and never two reads outstanding.
- Reset asserted while in R: the bridge is in IDLE on the next cycle, with no `data_ok` for the aborted read.
